// File: rtl/seq_magnitude_compare_if.sv
// ---------------------------------------------------------------------------
// seq_magnitude_compare_if
// Handshake and operand bundle for seq_magnitude_compare.
//   start        master -> slave  request a compare (sampled while busy=0)
//   signed_mode  master -> slave  1 = two's complement, 0 = unsigned
//   A, B         master -> slave  WIDTH-bit operands
//   busy         slave -> master  compare in progress
//   done         slave -> master  one-cycle pulse, result updated
//   eq, lt, gt   slave -> master  registered result, held until next done
// ---------------------------------------------------------------------------
interface seq_magnitude_compare_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             eq;
  logic             lt;
  logic             gt;

  modport master (
    output start, signed_mode, A, B,
    input  busy, done, eq, lt, gt
  );

  modport slave (
    input  start, signed_mode, A, B,
    output busy, done, eq, lt, gt
  );
endinterface

// File: rtl/seq_magnitude_compare.sv
// ---------------------------------------------------------------------------
// seq_magnitude_compare
// Sequential WIDTH-bit magnitude comparator. Compares CHUNK bits per clock,
// most-significant chunk first, and finishes at the first differing chunk.
// Signed compares are turned into unsigned ones by flipping both MSBs when
// the operands are latched.
//
// Ports:
//   clk   input   system clock, rising edge
//   rst   input   asynchronous, active-high reset
//   bus   slave   start/signed_mode/A/B in, busy/done/eq/lt/gt out
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; result outputs hold the last compare
// RUN   | comparing chunk idx; idx counts down from NCHUNK-1 to 0
// ---------------------------------------------------------------------------
module seq_magnitude_compare #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_magnitude_compare_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);
  localparam int unsigned CW = CHUNK;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             chunk_ne;

  // Chunk currently under comparison.
  always_comb begin
    a_chunk  = a_q[32'(idx_q) * CW +: CHUNK];
    b_chunk  = b_q[32'(idx_q) * CW +: CHUNK];
    chunk_ne = (a_chunk != b_chunk);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  // Next-state and operand/index datapath
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d = bus.A;
          b_d = bus.B;
          // Offset binary: flipping both sign bits maps two's-complement
          // order onto unsigned order, so the rest stays unsigned-only.
          if (bus.signed_mode) begin
            a_d[WIDTH-1] = ~bus.A[WIDTH-1];
            b_d[WIDTH-1] = ~bus.B[WIDTH-1];
          end
          idx_d   = IDX_TOP;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (chunk_ne || (idx_q == '0)) begin
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs: next values
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    eq_d   = eq_q;
    lt_d   = lt_q;
    gt_d   = gt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
        end
      end
      S_RUN: begin
        if (chunk_ne) begin
          eq_d   = 1'b0;
          lt_d   = (a_chunk < b_chunk);
          gt_d   = (a_chunk > b_chunk);
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (idx_q == '0) begin
          eq_d   = 1'b1;
          lt_d   = 1'b0;
          gt_d   = 1'b0;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.eq   = eq_q;
  assign bus.lt   = lt_q;
  assign bus.gt   = gt_q;

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// ---------------------------------------------------------------------------
// tb_seq_magnitude_compare
// Four comparators (CHUNK = 4, 1, 8, 16; WIDTH = 16) share one stimulus
// stream. A cycle-level model built from plain signed/unsigned arithmetic and
// a first-differing-chunk latency rule predicts busy/done/eq/lt/gt of each
// instance, checked every falling edge. Directed cases on the CHUNK=4
// instance carry hand-computed results and latencies.
// ---------------------------------------------------------------------------
module tb_seq_magnitude_compare;

  localparam int W = 16;
  localparam int CH [4] = '{4, 1, 8, 16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start_r = 1'b0;
  logic         smode_r = 1'b0;
  logic [W-1:0] a_r = '0;
  logic [W-1:0] b_r = '0;

  seq_magnitude_compare_if #(.WIDTH(W)) if0 ();
  seq_magnitude_compare_if #(.WIDTH(W)) if1 ();
  seq_magnitude_compare_if #(.WIDTH(W)) if2 ();
  seq_magnitude_compare_if #(.WIDTH(W)) if3 ();

  assign if0.start = start_r; assign if0.signed_mode = smode_r; assign if0.A = a_r; assign if0.B = b_r;
  assign if1.start = start_r; assign if1.signed_mode = smode_r; assign if1.A = a_r; assign if1.B = b_r;
  assign if2.start = start_r; assign if2.signed_mode = smode_r; assign if2.A = a_r; assign if2.B = b_r;
  assign if3.start = start_r; assign if3.signed_mode = smode_r; assign if3.A = a_r; assign if3.B = b_r;

  seq_magnitude_compare #(.WIDTH(W), .CHUNK(4))  u_c4  (.clk(clk), .rst(rst), .bus(if0.slave));
  seq_magnitude_compare #(.WIDTH(W), .CHUNK(1))  u_c1  (.clk(clk), .rst(rst), .bus(if1.slave));
  seq_magnitude_compare #(.WIDTH(W), .CHUNK(8))  u_c8  (.clk(clk), .rst(rst), .bus(if2.slave));
  seq_magnitude_compare #(.WIDTH(W), .CHUNK(16)) u_c16 (.clk(clk), .rst(rst), .bus(if3.slave));

  logic [4:0] obs [4];
  assign obs[0] = {if0.busy, if0.done, if0.eq, if0.lt, if0.gt};
  assign obs[1] = {if1.busy, if1.done, if1.eq, if1.lt, if1.gt};
  assign obs[2] = {if2.busy, if2.done, if2.eq, if2.lt, if2.gt};
  assign obs[3] = {if3.busy, if3.done, if3.eq, if3.lt, if3.gt};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected {eq,lt,gt} straight from the arithmetic meaning of the compare.
  function automatic logic [2:0] exp_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sm);
    if (a == b) return 3'b100;
    if (sm) return ($signed(a) < $signed(b)) ? 3'b010 : 3'b001;
    return (a < b) ? 3'b010 : 3'b001;
  endfunction

  // Cycles from the start edge to done: position (from the top, 1-based) of
  // the first chunk that differs, or the chunk count when equal.
  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input int ch);
    logic [31:0] x;
    int nch;
    x   = 32'(a ^ b);
    nch = W / ch;
    for (int k = 1; k <= nch; k++) begin
      if (((x >> ((nch - k) * ch)) & ((32'd1 << ch) - 32'd1)) != 32'd0) return k;
    end
    return nch;
  endfunction

  // Cycle-level model of each instance
  logic [3:0] m_busy;
  logic [3:0] m_done;
  logic [2:0] m_res  [4];
  logic [2:0] m_pend [4];
  int         m_rem  [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= '0;
      m_done <= '0;
      for (int i = 0; i < 4; i++) begin
        m_res[i]  <= 3'b000;
        m_pend[i] <= 3'b000;
        m_rem[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_done[i] <= 1'b0;
        if (!m_busy[i]) begin
          if (start_r) begin
            m_busy[i] <= 1'b1;
            m_rem[i]  <= exp_lat(a_r, b_r, CH[i]);
            m_pend[i] <= exp_res(a_r, b_r, smode_r);
          end
        end else if (m_rem[i] == 1) begin
          m_busy[i] <= 1'b0;
          m_done[i] <= 1'b1;
          m_res[i]  <= m_pend[i];
        end else begin
          m_rem[i] <= m_rem[i] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("cycle_chunk%0d", CH[i]), 32'(obs[i]),
            32'({m_busy[i], m_done[i], m_res[i]}));
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    a_r     = a;
    b_r     = b;
    smode_r = sm;
    start_r = 1'b1;
  endtask

  // Lets the start edge pass, then counts cycles to done on the CHUNK=4 unit.
  task automatic wait_done(output int lat, output logic [2:0] r);
    @(posedge clk);
    #1 start_r = 1'b0;
    lat = 0;
    r   = 3'bxxx;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if0.done) begin
        r = {if0.eq, if0.lt, if0.gt};
        return;
      end
      lat++;
    end
    n_chk++;
    $display("FAIL wait_done: timeout, no done within 40 cycles");
  endtask

  task automatic wait_all_idle();
    for (int c = 0; c < 40; c++) begin
      if (m_busy == 4'b0000) return;
      @(posedge clk);
      #1;
    end
    n_chk++;
    $display("FAIL wait_idle: model still busy, got %b expected 0000", m_busy);
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sm, input int lat_e, input logic [2:0] res_e);
    int lat;
    logic [2:0] r;
    wait_all_idle();
    drive(a, b, sm);
    wait_done(lat, r);
    chk({name, "_lat"}, 32'(lat), 32'(lat_e));
    chk({name, "_res"}, 32'(r), 32'(res_e));
  endtask

  initial begin
    int lat;
    int ndone;
    logic [2:0] r;
    logic [W-1:0] ra, rb;

    // Pin the model with hand-computed values.
    chk("model_lat_c1_eq16",  32'(exp_lat(16'h1234, 16'h1235, 1)), 32'd16);
    chk("model_lat_c1_top",   32'(exp_lat(16'h8000, 16'h0000, 1)), 32'd1);
    chk("model_lat_c8_low",   32'(exp_lat(16'h00F0, 16'h00E0, 8)), 32'd2);
    chk("model_res_signed",   32'(exp_res(16'hFFFF, 16'h0001, 1'b1)), 32'b010);
    chk("model_res_unsigned", 32'(exp_res(16'hFFFF, 16'h0001, 1'b0)), 32'b001);

    #12;
    chk("reset_outputs", 32'(obs[0]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // A=B: busy 4 cycles, eq
    wait_all_idle();
    drive(16'hBEEF, 16'hBEEF, 1'b0);
    wait_done(lat, r);
    chk("beef_lat", 32'(lat), 32'd4);
    chk("beef_res", 32'(r), 32'b100);
    // new start in the done cycle is accepted
    drive(16'h1000, 16'h0FFF, 1'b0);
    wait_done(lat, r);
    chk("b2b_lat", 32'(lat), 32'd1);
    chk("b2b_res", 32'(r), 32'b001);

    directed("lsb_lt",      16'h1234, 16'h1235, 1'b0, 4, 3'b010);
    directed("ffff_signed", 16'hFFFF, 16'h0001, 1'b1, 1, 3'b010);
    directed("ffff_unsig",  16'hFFFF, 16'h0001, 1'b0, 1, 3'b001);
    directed("8000_signed", 16'h8000, 16'h7FFF, 1'b1, 1, 3'b010);
    directed("mid_gt",      16'h00F0, 16'h00E0, 1'b0, 3, 3'b001);
    directed("eq_zero",     16'h0000, 16'h0000, 1'b0, 4, 3'b100);

    // start while busy is ignored; operand change during RUN has no effect
    wait_all_idle();
    drive(16'h0000, 16'h0000, 1'b0);
    @(posedge clk);
    #1 start_r = 1'b0;
    @(posedge clk);
    #1 a_r = 16'hFFFF; start_r = 1'b1;
    @(posedge clk);
    #1 start_r = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if0.done) begin
        ndone++;
        r = {if0.eq, if0.lt, if0.gt};
      end
    end
    chk("ignored_start_ndone", 32'(ndone), 32'd1);
    chk("ignored_start_res", 32'(r), 32'b100);

    // reset in the middle of a compare
    wait_all_idle();
    drive(16'h5555, 16'h5555, 1'b0);
    @(posedge clk);
    #1 start_r = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("midrun_reset_outputs", 32'(obs[0]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    directed("after_reset", 16'h00F0, 16'h00E0, 1'b0, 3, 3'b001);

    // random sweep, both modes, all chunk sizes via the per-cycle model
    for (int m = 0; m < 2; m++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = W'($urandom);
        case ($urandom_range(0, 3))
          0:       rb = ra;
          1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
          default: rb = W'($urandom);
        endcase
        wait_all_idle();
        drive(ra, rb, m[0]);
        @(posedge clk);
        #1 start_r = 1'b0;
      end
    end
    wait_all_idle();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
